// File: rtl/baud_pkg.sv
// Shared defaults and reset divisors for the baud tick generator.
// Divisors assume a 100 MHz clock and 16x oversampling, rounded to nearest.
// Imported by baud_tick_gen and its testbench.
package baud_pkg;

  localparam int DIV_W_DEF  = 16;
  localparam int FRAC_W_DEF = 4;
  localparam int OVS_DEF    = 16;
  localparam int CLK_HZ     = 100_000_000;

  // Nearest-integer clk-per-s_tick divisor for a given baud rate.
  function automatic int baud_div(input int clk_hz, input int baud, input int ovs);
    return (clk_hz + (baud * ovs) / 2) / (baud * ovs);
  endfunction

  localparam int DIV_9600   = baud_div(CLK_HZ, 9600, OVS_DEF);    // 651
  localparam int DIV_19200  = baud_div(CLK_HZ, 19200, OVS_DEF);   // 326
  localparam int DIV_115200 = baud_div(CLK_HZ, 115200, OVS_DEF);  // 54

  localparam int RST_DIV_DEF = DIV_9600;

endpackage

// File: rtl/ovs_divider.sv
// Mod-OVS counter: one terminal tick every OVS advance pulses.
// Tick is combinational from the registered count (zero latency).
// No backpressure; clr has priority over adv.
module ovs_divider #(
  parameter int OVS = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic adv,
  output logic tick
);

  localparam int CW = (OVS > 1) ? $clog2(OVS) : 1;
  localparam logic [CW-1:0] LAST = CW'(OVS - 1);

  logic [CW-1:0] cnt;

  assign tick = adv && (cnt == LAST);

  // Count advance pulses, wrapping at OVS-1; clr restarts from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (adv) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/baud_tick_gen.sv
// Fractional-N baud tick generator: s_tick every P clks, b_tick every OVS s_ticks.
// Ticks are zero-latency decodes of registered state; divisor swaps at a wrap.
// cfg_ready stays low while an update is pending. Macro BAUD_FRAC_EN builds the
// fractional accumulator; without it cfg_frac is ignored and P = active_div.
module baud_tick_gen
  import baud_pkg::*;
#(
  parameter int DIV_W   = DIV_W_DEF,
  parameter int FRAC_W  = FRAC_W_DEF,
  parameter int OVS     = OVS_DEF,
  parameter int RST_DIV = RST_DIV_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [FRAC_W-1:0] cfg_frac,
  output logic              s_tick,
  output logic              b_tick,
  output logic [DIV_W-1:0]  q
);

  logic [DIV_W-1:0] count;
  logic [DIV_W-1:0] active_div;
  logic [DIV_W-1:0] pend_div;
  logic             pend_vld;
  logic [DIV_W:0]   period;
  logic             div_zero;
  logic             wrap;
  logic             accept;
  logic             apply;

`ifdef BAUD_FRAC_EN
  logic [FRAC_W-1:0] acc;
  logic [FRAC_W-1:0] active_frac;
  logic [FRAC_W-1:0] pend_frac;
  logic              long_per;
  logic [FRAC_W:0]   acc_sum;

  // A carry out of the accumulator stretches the next period by one clk.
  assign period  = {1'b0, active_div} + (DIV_W+1)'(long_per);
  assign acc_sum = {1'b0, acc} + {1'b0, active_frac};
`else
  logic unused_frac;
  assign unused_frac = ^cfg_frac;
  assign period      = {1'b0, active_div};
`endif

  assign div_zero  = (active_div == '0);
  assign wrap      = en && !rst && !div_zero && ({1'b0, count} == period - (DIV_W+1)'(1));
  assign s_tick    = wrap;
  assign cfg_ready = !pend_vld;
  assign accept    = cfg_valid && cfg_ready;
  // Swap at a wrap, or straight away when the counter is not running.
  assign apply     = pend_vld && (wrap || !en || div_zero);
  assign q         = count;

  // Period counter, active divisor and the single-entry pending register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count      <= '0;
      active_div <= DIV_W'(RST_DIV);
      pend_div   <= '0;
      pend_vld   <= 1'b0;
    end else if (apply) begin
      active_div <= pend_div;
      count      <= '0;
      pend_vld   <= 1'b0;
    end else begin
      if (accept) begin
        pend_div <= cfg_div;
        pend_vld <= 1'b1;
      end
      if (div_zero || wrap) begin
        count <= '0;
      end else if (en) begin
        count <= count + 1'b1;
      end
    end
  end

`ifdef BAUD_FRAC_EN
  // Fractional accumulator: steps once per wrap, cleared when a new divisor lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc         <= '0;
      long_per    <= 1'b0;
      active_frac <= '0;
      pend_frac   <= '0;
    end else if (apply) begin
      acc         <= '0;
      long_per    <= 1'b0;
      active_frac <= pend_frac;
    end else begin
      if (accept) begin
        pend_frac <= cfg_frac;
      end
      if (wrap) begin
        acc      <= acc_sum[FRAC_W-1:0];
        long_per <= acc_sum[FRAC_W];
      end
    end
  end
`endif

  ovs_divider #(
    .OVS (OVS)
  ) u_ovs (
    .clk  (clk),
    .rst  (rst),
    .clr  (apply),
    .adv  (wrap),
    .tick (b_tick)
  );

endmodule

// File: tb/tb_baud_tick_gen.sv
// Directed + randomized bench for baud_tick_gen against a cycle-level reference model.
module tb_baud_tick_gen;

  localparam int DIV_W   = 16;
  localparam int FRAC_W  = 4;
  localparam int OVS     = 16;
  localparam int RST_DIV = 4;
  localparam int LIM     = 2000;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [DIV_W-1:0]  cfg_div;
  logic [FRAC_W-1:0] cfg_frac;
  logic              s_tick;
  logic              b_tick;
  logic [DIV_W-1:0]  q;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  baud_tick_gen #(
    .DIV_W   (DIV_W),
    .FRAC_W  (FRAC_W),
    .OVS     (OVS),
    .RST_DIV (RST_DIV)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_div   (cfg_div),
    .cfg_frac  (cfg_frac),
    .s_tick    (s_tick),
    .b_tick    (b_tick),
    .q         (q)
  );

  // Reference state, in spec terms: position in period, divisor, extra-clk flag,
  // position in the s_tick group, and the one pending update.
  int m_cnt, m_div, m_long, m_ovs, m_pend, m_pdiv;
`ifdef BAUD_FRAC_EN
  int m_frac, m_acc, m_pfrac;
`endif

  // Observation log for timing checks.
  int cyc, last_st, ready_low;
  int iv_q[$];
  int st_cyc[$];
  int bt_cyc[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_bound(input string tag, input int n);
    tests++;
    assert (n < LIM) else begin
      fails++;
      $error("FAIL %s: waited %0d cycles, limit %0d", tag, n, LIM);
    end
  endtask

  function automatic int qat(input int qq[$], input int i);
    return (i < qq.size()) ? qq[i] : -1;
  endfunction

  function automatic bit m_stick();
    return en && (m_div != 0) && (m_cnt == m_div + m_long - 1);
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_div = RST_DIV; m_long = 0; m_ovs = 0; m_pend = 0; m_pdiv = 0;
`ifdef BAUD_FRAC_EN
    m_frac = 0; m_acc = 0; m_pfrac = 0;
`endif
  endtask

  task automatic model_adv();
    bit st;
    bit take;
    st   = m_stick();
    take = cfg_valid && !m_pend;
    if (m_pend && (st || !en || m_div == 0)) begin
      m_div = m_pdiv; m_cnt = 0; m_long = 0; m_ovs = 0; m_pend = 0;
`ifdef BAUD_FRAC_EN
      m_frac = m_pfrac; m_acc = 0;
`endif
    end else begin
      if (st) begin
        m_cnt = 0;
        m_ovs = (m_ovs + 1) % OVS;
`ifdef BAUD_FRAC_EN
        m_long = ((m_acc + m_frac) >= (1 << FRAC_W)) ? 1 : 0;
        m_acc  = (m_acc + m_frac) % (1 << FRAC_W);
`endif
      end else if (m_div == 0) begin
        m_cnt = 0;
      end else if (en) begin
        m_cnt++;
      end
      if (take) begin
        m_pend = 1; m_pdiv = int'(cfg_div);
`ifdef BAUD_FRAC_EN
        m_pfrac = int'(cfg_frac);
`endif
      end
    end
  endtask

  task automatic clear_stats();
    cyc = 0; last_st = -1; ready_low = 0;
    iv_q.delete(); st_cyc.delete(); bt_cyc.delete();
  endtask

  // One clk: check outputs mid-cycle, then advance the model at the edge.
  task automatic step();
    bit st;
    #1;
    st = m_stick();
    chk("q", 32'(q), m_cnt);
    chk("s_tick", 32'(s_tick), 32'(st));
    chk("b_tick", 32'(b_tick), 32'(st && (m_ovs == OVS - 1)));
    chk("cfg_ready", 32'(cfg_ready), 32'(m_pend == 0));
    if (s_tick === 1'b1) begin
      if (last_st >= 0) iv_q.push_back(cyc - last_st);
      last_st = cyc;
      st_cyc.push_back(cyc);
    end
    if (b_tick === 1'b1) bt_cyc.push_back(cyc);
    if (cfg_ready !== 1'b1) ready_low++;
    @(posedge clk);
    model_adv();
    cyc++;
    @(negedge clk);
  endtask

  task automatic load(input int d, input int f);
    int n;
    n = 0;
    while (m_pend != 0 && n < LIM) begin step(); n++; end
    cfg_valid = 1'b1; cfg_div = DIV_W'(d); cfg_frac = FRAC_W'(f);
    step();
    cfg_valid = 1'b0;
    while (m_pend != 0 && n < LIM) begin step(); n++; end
    chk_bound("load_wait", n);
  endtask

  task automatic wait_cnt(input int v);
    int n;
    n = 0;
    while (m_cnt != v && n < LIM) begin step(); n++; end
    chk_bound("count_wait", n);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b1; cfg_valid = 1'b0; cfg_div = '0; cfg_frac = '0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_q", 32'(q), 0);
    chk("rst_ready", 32'(cfg_ready), 1);
    chk("rst_s", 32'(s_tick), 0);
    chk("rst_b", 32'(b_tick), 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Reset divisor 4: s_tick at 3,7,...; b_tick at 63, 127.
    clear_stats();
    repeat (130) step();
    chk("p34_first_s", qat(st_cyc, 0), 3);
    chk("p34_s_count", st_cyc.size(), 32);
    chk("p34_first_b", qat(bt_cyc, 0), 63);
    chk("p34_b_gap", qat(bt_cyc, 1) - qat(bt_cyc, 0), 64);

    // div=10, then div=5 offered at count 4: pending through the count-9 wrap.
    load(10, 0);
    wait_cnt(4);
    clear_stats();
    cfg_valid = 1'b1; cfg_div = 16'd5; cfg_frac = 4'd0;
    step();
    cfg_valid = 1'b0;
    begin
      int n;
      n = 0;
      while (m_pend != 0 && n < LIM) begin step(); n++; end
      chk_bound("p36_wait", n);
    end
    chk("p36_ready_low", ready_low, 5);
    clear_stats();
    repeat (85) step();
    chk("p36_first_s", qat(st_cyc, 0), 4);
    chk("p36_first_b", qat(bt_cyc, 0), 79);
    for (int i = 0; i < 4; i++) chk("p36_period", qat(iv_q, i), 5);

    // Offer accepted on a wrap cycle: one more old period, then the new one.
    wait_cnt(4);
    clear_stats();
    cfg_valid = 1'b1; cfg_div = 16'd7;
    step();
    cfg_valid = 1'b0;
    repeat (20) step();
    chk("p37_old", qat(iv_q, 0), 5);
    chk("p37_new", qat(iv_q, 1), 7);
    chk("p37_ready_low", ready_low, 5);

    // en low for 7 cycles at count 2.
    wait_cnt(2);
    en = 1'b0;
    clear_stats();
    repeat (7) step();
    chk("p38_hold_q", 32'(q), 2);
    chk("p38_no_tick", st_cyc.size() + bt_cyc.size(), 0);
    en = 1'b1;
    step();
    chk("p38_resume_q", 32'(q), 3);

    // div=3 frac=8: 3,4,3,4 with the accumulator, constant 3 without.
    load(3, 8);
    clear_stats();
    repeat (40) step();
    begin
      int sum;
      sum = 0;
      for (int i = 0; i < 8; i++) sum += qat(iv_q, i + 1);
`ifdef BAUD_FRAC_EN
      chk("p35_sum8", sum, 28);
      chk("p35_iv1", qat(iv_q, 1), 4);
      chk("p35_iv2", qat(iv_q, 2), 3);
`else
      chk("p35_sum8", sum, 24);
      chk("p35_iv1", qat(iv_q, 1), 3);
`endif
    end

    // div=1: tick every enabled cycle.
    load(1, 0);
    clear_stats();
    repeat (10) step();
    chk("div1_ticks", st_cyc.size(), 10);

    // div=0: held at zero, no ticks; a new divisor lands on the next cycle.
    load(0, 0);
    clear_stats();
    repeat (10) step();
    chk("div0_ticks", st_cyc.size(), 0);
    clear_stats();
    load(6, 0);
    chk("div0_ready_low", ready_low, 1);

    // Random en and cfg traffic.
    for (int i = 0; i < 400; i++) begin
      en = ($urandom_range(0, 9) != 0);
      cfg_valid = ($urandom_range(0, 15) == 0);
      cfg_div   = DIV_W'($urandom_range(0, 12));
      cfg_frac  = FRAC_W'($urandom);
      step();
    end
    en = 1'b1; cfg_valid = 1'b0;

    // Reset mid-period with an update pending.
    load(400, 0);
    wait_cnt(300);
    cfg_valid = 1'b1; cfg_div = 16'd9;
    step();
    cfg_valid = 1'b0;
    step();
    rst = 1'b1;
    #1;
    chk("p39_q", 32'(q), 0);
    chk("p39_ready", 32'(cfg_ready), 1);
    chk("p39_s", 32'(s_tick), 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    clear_stats();
    repeat (70) step();
    chk("p39_first_s", qat(st_cyc, 0), 3);
    chk("p39_first_b", qat(bt_cyc, 0), 63);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
